// File: rtl/usr_serdes_ctrl_if.sv
// Handshake bundle between the SERDES sequencer and its word/bit producers and consumers.
// The master side drives words/bits in and accepts bits/words out; the slave is the sequencer.
interface usr_serdes_ctrl_if #(
    parameter int N = 8
);
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready;
    logic         sin;
    logic         sin_valid;
    logic         sin_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;

    modport master (
        output tx_data, tx_valid, sout_ready, sin, sin_valid, rx_ready,
        input  tx_ready, sout, sout_valid, sin_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, sout_ready, sin, sin_valid, rx_ready,
        output tx_ready, sout, sout_valid, sin_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/usr_serdes_ctrl.sv
// Half-duplex SERDES sequencer driving an external universal shift register
// (sel 0 hold, 1 shift right, 2 shift left, 3 parallel load).
module usr_serdes_ctrl #(
    parameter int N = 8,
    localparam int SEL_W = $clog2(N),
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_abort,
    input  logic             i_lsb_first,
    output logic             o_busy,
    output logic [SEL_W-1:0] o_sr_sel,
    output logic [N-1:0]     o_sr_din,
    input  logic [N-1:0]     i_sr_dout,
    usr_serdes_ctrl_if.slave bus
);

    localparam logic [SEL_W-1:0] SEL_HOLD = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_SR   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SL   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX_SHIFT,
        ST_RX_SHIFT,
        ST_RX_HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_dir_nxt;
    logic [SEL_W-1:0]   w_sel;
    logic [N-1:0]       w_din;
    logic               w_tx_ready;
    logic               w_sin_ready;
    logic               w_sout_valid;
    logic               w_rx_valid;
    logic               w_rx_dir;
    logic [SEL_W-1:0]   w_rx_sel;
    logic [N-1:0]       w_rx_din;

    // The first RX bit is taken in IDLE, before dir_q has captured the bit order.
    assign w_rx_dir = (r_state == ST_IDLE) ? i_lsb_first : r_dir;
    assign w_rx_sel = w_rx_dir ? SEL_SR : SEL_SL;
    assign w_rx_din = w_rx_dir ? {bus.sin, {(N-1){1'b0}}} : {{(N-1){1'b0}}, bus.sin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_nxt    = r_dir;
        w_sel        = SEL_HOLD;
        w_din        = '0;
        w_tx_ready   = 1'b0;
        w_sin_ready  = 1'b0;
        w_sout_valid = 1'b0;
        w_rx_valid   = 1'b0;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tx_ready  = 1'b1;
                    w_sin_ready = ~bus.tx_valid;
                    if (bus.tx_valid) begin
                        w_sel       = SEL_LOAD;
                        w_din       = bus.tx_data;
                        w_dir_nxt   = i_lsb_first;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_TX_SHIFT;
                    end else if (bus.sin_valid) begin
                        w_sel       = w_rx_sel;
                        w_din       = w_rx_din;
                        w_dir_nxt   = i_lsb_first;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_RX_SHIFT;
                    end
                end
                ST_TX_SHIFT: begin
                    w_sout_valid = 1'b1;
                    if (bus.sout_ready) begin
                        w_sel     = r_dir ? SEL_SR : SEL_SL;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(N - 1)) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_RX_SHIFT: begin
                    w_sin_ready = 1'b1;
                    if (bus.sin_valid) begin
                        w_sel     = w_rx_sel;
                        w_din     = w_rx_din;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(N - 1)) begin
                            w_state_nxt = ST_RX_HOLD;
                        end
                    end
                end
                ST_RX_HOLD: begin
                    w_rx_valid = 1'b1;
                    if (bus.rx_ready) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_sr_sel       = w_sel;
    assign o_sr_din       = w_din;
    assign bus.tx_ready   = w_tx_ready;
    assign bus.sin_ready  = w_sin_ready;
    assign bus.sout_valid = w_sout_valid;
    assign bus.rx_valid   = w_rx_valid;
    assign bus.sout       = r_dir ? i_sr_dout[0] : i_sr_dout[N-1];
    assign bus.rx_data    = i_sr_dout;

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// Directed bench for usr_serdes_ctrl with a behavioural 8-bit universal shift register attached.
module tb_usr_serdes_ctrl;

    logic       clk;
    logic       rst;
    logic       abort;
    logic       lsb_first;
    logic       busy;
    logic [2:0] sr_sel;
    logic [7:0] sr_din;
    logic [7:0] sr_q;
    int         n_vec;
    int         n_bad;

    usr_serdes_ctrl_if #(.N(8)) bus ();

    usr_serdes_ctrl #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_abort    (abort),
        .i_lsb_first(lsb_first),
        .o_busy     (busy),
        .o_sr_sel   (sr_sel),
        .o_sr_din   (sr_din),
        .i_sr_dout  (sr_q),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External universal shift register (not cleared by the controller's reset).
    initial sr_q = 8'h00;
    always @(posedge clk) begin
        case (sr_sel)
            3'd1:    sr_q <= {sr_din[7], sr_q[7:1]};
            3'd2:    sr_q <= {sr_q[6:0], sr_din[0]};
            3'd3:    sr_q <= sr_din;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tx_frame(input logic [7:0] w, input logic lsb);
        @(negedge clk);
        bus.tx_valid   = 1'b1;
        bus.tx_data    = w;
        lsb_first      = lsb;
        bus.sout_ready = 1'b1;
        #1;
        chk("tx_ready_idle", 32'(bus.tx_ready), 32'd1);
        chk("tx_load_sel", 32'(sr_sel), 32'd3);
        chk("tx_load_din", 32'(sr_din), 32'(w));
        @(negedge clk);
        bus.tx_valid = 1'b0;
        lsb_first    = ~lsb;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tx_sout_valid", 32'(bus.sout_valid), 32'd1);
            chk("tx_sout_bit", 32'(bus.sout), 32'(lsb ? w[i] : w[7-i]));
            chk("tx_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("tx_end_busy", 32'(busy), 32'd0);
        chk("tx_end_sout_valid", 32'(bus.sout_valid), 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] w, input logic lsb);
        @(negedge clk);
        lsb_first = lsb;
        for (int i = 0; i < 8; i++) begin
            bus.sin       = lsb ? w[i] : w[7-i];
            bus.sin_valid = 1'b1;
            #1;
            chk("rx_sin_ready", 32'(bus.sin_ready), 32'd1);
            chk("rx_valid_early", 32'(bus.rx_valid), 32'd0);
            @(negedge clk);
            if (i == 0) lsb_first = ~lsb;
        end
        bus.sin_valid = 1'b0;
        #1;
        chk("rx_valid", 32'(bus.rx_valid), 32'd1);
        chk("rx_data", 32'(bus.rx_data), 32'(w));
        chk("rx_hold_sin_ready", 32'(bus.sin_ready), 32'd0);
        chk("rx_hold_tx_ready", 32'(bus.tx_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rx_valid_held", 32'(bus.rx_valid), 32'd1);
        chk("rx_data_held", 32'(bus.rx_data), 32'(w));
        chk("rx_hold_sel", 32'(sr_sel), 32'd0);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        #1;
        chk("rx_end_busy", 32'(busy), 32'd0);
        chk("rx_end_valid", 32'(bus.rx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        int         k;
        int         cyc;
        logic       rdy;
        logic       held;

        n_vec          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        abort          = 1'b0;
        lsb_first      = 1'b0;
        bus.tx_data    = 8'h00;
        bus.tx_valid   = 1'b0;
        bus.sout_ready = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.rx_ready   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_sin_ready", 32'(bus.sin_ready), 32'd1);
        chk("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_sr_sel", 32'(sr_sel), 32'd0);
        chk("rst_sr_din", 32'(sr_din), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // TX LSB-first 0xA5 at full rate
        tx_frame(8'hA5, 1'b1);

        // TX MSB-first 0xA5 with sout_ready toggling
        w = 8'hA5;
        @(negedge clk);
        bus.tx_valid   = 1'b1;
        bus.tx_data    = w;
        lsb_first      = 1'b0;
        bus.sout_ready = 1'b1;
        #1;
        chk("msb_load_sel", 32'(sr_sel), 32'd3);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        k   = 0;
        cyc = 0;
        rdy = 1'b1;
        while (k < 8 && cyc < 40) begin
            bus.sout_ready = rdy;
            #1;
            chk("msb_sout_valid", 32'(bus.sout_valid), 32'd1);
            chk("msb_sout_bit", 32'(bus.sout), 32'(w[7-k]));
            if (!rdy) chk("msb_hold_sel", 32'(sr_sel), 32'd0);
            if (rdy) k++;
            rdy = ~rdy;
            cyc++;
            @(negedge clk);
        end
        chk("msb_bits_sent", 32'(k), 32'd8);
        #1;
        chk("msb_end_busy", 32'(busy), 32'd0);

        // RX LSB-first bits 1,1,0,0,0,0,0,1 -> 0x83
        rx_frame(8'h83, 1'b1);

        // Simultaneous TX and RX request in IDLE: TX wins
        @(negedge clk);
        bus.tx_valid   = 1'b1;
        bus.tx_data    = 8'h0F;
        bus.sin_valid  = 1'b1;
        bus.sin        = 1'b1;
        lsb_first      = 1'b1;
        bus.sout_ready = 1'b1;
        #1;
        chk("sim_sin_ready", 32'(bus.sin_ready), 32'd0);
        chk("sim_sel", 32'(sr_sel), 32'd3);
        @(negedge clk);
        bus.tx_valid  = 1'b0;
        bus.sin_valid = 1'b0;
        #1;
        chk("sim_tx_state", 32'(bus.sout_valid), 32'd1);
        chk("sim_sin_ready_tx", 32'(bus.sin_ready), 32'd0);

        // Three bits out, then abort
        for (int i = 0; i < 3; i++) begin
            held = bus.sout;
            chk("abt_sout_bit", 32'(held), 32'(w[i] ^ 1'b0 ^ (8'h0F >> i & 1) ^ w[i]));
            @(negedge clk);
            #1;
        end
        abort = 1'b1;
        #1;
        chk("abt_sel", 32'(sr_sel), 32'd0);
        chk("abt_sout_valid", 32'(bus.sout_valid), 32'd0);
        chk("abt_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("abt_sin_ready", 32'(bus.sin_ready), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abt_idle_busy", 32'(busy), 32'd0);
        chk("abt_idle_sout_valid", 32'(bus.sout_valid), 32'd0);

        tx_frame(8'h3C, 1'b0);

        // Reset four bits into an RX frame
        @(negedge clk);
        lsb_first = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sin       = i[0];
            bus.sin_valid = 1'b1;
            @(negedge clk);
        end
        bus.sin_valid = 1'b0;
        #1;
        chk("mid_rx_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rx_rst_busy", 32'(busy), 32'd0);
        chk("mid_rx_rst_sel", 32'(sr_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rx_frame(8'h5A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
